ask4_slicer: RTL



---
 rtl/ask4_pkg.sv | 29 ++
 rtl/ask4_est_acc.sv | 87 ++++++++
 rtl/ask4_slicer.sv | 92 +++++++++
 3 files changed

// File: rtl/ask4_pkg.sv
// Shared types and constants for the 4-ASK receive slicer.
// Latency: none (types and a combinational helper only).
// Backpressure: none; the slicer path is free-running.
package ask4_pkg;

    // Gray-coded symbol: adjacent amplitude levels differ in one bit.
    typedef logic [1:0] sym_t;
    localparam sym_t SYM_M3 = 2'b00;
    localparam sym_t SYM_M1 = 2'b01;
    localparam sym_t SYM_P1 = 2'b11;
    localparam sym_t SYM_P3 = 2'b10;

    // Signed 1s17 matched-filter sample.
    typedef logic signed [17:0] sample_t;

    // 19-bit unsigned magnitude, wide enough for |-131072|.
    typedef logic [18:0] mag_t;

    // Default outer/inner threshold 2a = 0.5 in 1s17.
    localparam int REF_INIT_DEF = 65536;

    // Sign-extend before negating so the most negative sample does not wrap.
    function automatic mag_t abs19(input sample_t x);
        logic signed [18:0] xs;
        xs = {x[17], x};
        return x[17] ? mag_t'(-xs) : mag_t'(xs);
    endfunction

endpackage

// File: rtl/ask4_est_acc.sv
// Block estimator: averages |x| and |slicing error| over 2^ACC_LOG2 symbols.
// Latency: ref_level/mae/blk_valid register one cycle after the last in_vld of a block.
// Backpressure: none; accepts one symbol per in_vld, never stalls.
// Ports: clk, reset (sync, active-high); in_vld/in_abs/in_err per decided symbol;
//        ref_level (threshold 2a), mae (mean |error|), blk_valid (update strobe).
module ask4_est_acc
    import ask4_pkg::*;
#(
    parameter int ACC_LOG2 = 10,
    parameter int REF_INIT = REF_INIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vld,
    input  mag_t        in_abs,
    input  mag_t        in_err,
    output logic [17:0] ref_level,
    output logic [17:0] mae,
    output logic        blk_valid
);

    localparam int SW = ACC_LOG2 + 19;

    logic [ACC_LOG2-1:0] cnt_q, cnt_d;
    logic [SW-1:0]       sum_abs_q, sum_abs_d, sum_err_q, sum_err_d;
    logic [17:0]         ref_q, ref_d, mae_q, mae_d;
    logic                blk_q, blk_d;

    logic [SW-1:0]       sum_abs_nx, sum_err_nx, avg_abs, avg_err;
    logic [17:0]         ref_sat, mae_sat;

    always_comb begin
        // Include the symbol arriving this cycle so the last one of a block counts.
        sum_abs_nx = sum_abs_q + SW'(in_abs);
        sum_err_nx = sum_err_q + SW'(in_err);
        avg_abs    = sum_abs_nx >> ACC_LOG2;
        avg_err    = sum_err_nx >> ACC_LOG2;
        ref_sat    = (|avg_abs[SW-1:18]) ? 18'h3FFFF : avg_abs[17:0];
        mae_sat    = (|avg_err[SW-1:18]) ? 18'h3FFFF : avg_err[17:0];

        cnt_d     = cnt_q;
        sum_abs_d = sum_abs_q;
        sum_err_d = sum_err_q;
        ref_d     = ref_q;
        mae_d     = mae_q;
        blk_d     = 1'b0;

        if (in_vld) begin
            if (cnt_q == '1) begin
                // A zero threshold would make the outer/inner decision degenerate.
                ref_d     = (ref_sat == 18'd0) ? 18'd1 : ref_sat;
                mae_d     = mae_sat;
                blk_d     = 1'b1;
                cnt_d     = '0;
                sum_abs_d = '0;
                sum_err_d = '0;
            end else begin
                cnt_d     = cnt_q + 1'b1;
                sum_abs_d = sum_abs_nx;
                sum_err_d = sum_err_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            sum_abs_q <= '0;
            sum_err_q <= '0;
            ref_q     <= 18'(REF_INIT);
            mae_q     <= '0;
            blk_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sum_abs_q <= sum_abs_d;
            sum_err_q <= sum_err_d;
            ref_q     <= ref_d;
            mae_q     <= mae_d;
            blk_q     <= blk_d;
        end
    end

    assign ref_level = ref_q;
    assign mae       = mae_q;
    assign blk_valid = blk_q;

endmodule

// File: rtl/ask4_slicer.sv
// 4-ASK slicer: decimates SPS:1 at a selectable phase and slices against an adaptive threshold.
// Latency: sym_out/sym_valid one cycle after the phase match; block stats one cycle after that.
// Backpressure: none; one input sample per clock, outputs are strobes.
// Ports: clk, reset (sync, active-high); x_in (1s17), sym_phase (decimation phase);
//        sym_out/sym_valid (Gray symbol); ref_level, mae, blk_valid (block estimates).
module ask4_slicer
    import ask4_pkg::*;
#(
    parameter int SPS      = 4,
    parameter int ACC_LOG2 = 10,
    parameter int REF_INIT = REF_INIT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [17:0]      x_in,
    input  logic [$clog2(SPS)-1:0]  sym_phase,
    output logic [1:0]              sym_out,
    output logic                    sym_valid,
    output logic [17:0]             ref_level,
    output logic [17:0]             mae,
    output logic                    blk_valid
);

    localparam int PW = $clog2(SPS);

    logic [PW-1:0] cnt_q, cnt_d;
    sym_t          sym_q, sym_d;
    logic          sym_vld_q, sym_vld_d;
    mag_t          abs_q, abs_d, err_q, err_d;

    mag_t          x_abs, r19, ideal, err;
    sym_t          dec;
    logic          match;

    always_comb begin
        x_abs = abs19(x_in);
        r19   = {1'b0, ref_level};

        // Negative side: strictly beyond -R is outer, so x = -R stays inner.
        // Positive side: x = R is already outer.
        if (x_in[17]) begin
            dec = (x_abs > r19) ? SYM_M3 : SYM_M1;
        end else begin
            dec = (x_abs >= r19) ? SYM_P3 : SYM_P1;
        end

        ideal = ((dec == SYM_M3) || (dec == SYM_P3)) ? (r19 + (r19 >> 1)) : (r19 >> 1);
        err   = (x_abs >= ideal) ? (x_abs - ideal) : (ideal - x_abs);

        // Power-of-two SPS lets the counter wrap naturally.
        match     = (cnt_q == sym_phase);
        cnt_d     = cnt_q + 1'b1;
        sym_vld_d = match;
        sym_d     = match ? dec   : sym_q;
        abs_d     = match ? x_abs : abs_q;
        err_d     = match ? err   : err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            sym_q     <= SYM_M3;
            sym_vld_q <= 1'b0;
            abs_q     <= '0;
            err_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            sym_q     <= sym_d;
            sym_vld_q <= sym_vld_d;
            abs_q     <= abs_d;
            err_q     <= err_d;
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = sym_vld_q;

    ask4_est_acc #(
        .ACC_LOG2 (ACC_LOG2),
        .REF_INIT (REF_INIT)
    ) u_est (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (sym_vld_q),
        .in_abs    (abs_q),
        .in_err    (err_q),
        .ref_level (ref_level),
        .mae       (mae),
        .blk_valid (blk_valid)
    );

endmodule
